axi_wr_arbiter_2to1: RTL and testbench

Two-requester AXI4 write-path arbiter that shares one AXI4 master port, i.e. one axi_if master-side connection, between two upstream write requesters.
- AW channel: round-robin arbitration, with the winner's index prepended to AWID.
- W channel: bursts follow AW grant order through a small order queue.
- B channel: responses routed back by the AWID MSB.
Sits between the two write sources and the DUT-facing AXI interface.

---
 rtl/axi_wr_arbiter_2to1.sv | 153 +++++++++++++++
 tb/tb_axi_wr_arbiter_2to1.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_wr_arbiter_2to1.sv
// Two-requester AXI4 write arbiter: round-robin AW grant, W bursts ordered by
// an AW-grant queue, B responses routed back by the master-side AWID MSB.
module axi_wr_arbiter_2to1 #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned WQ_DEPTH   = 4,
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic [1:0]                s_awvalid,
    output logic [1:0]                s_awready,
    input  logic [2*ID_WIDTH-1:0]     s_awid,
    input  logic [2*ADDR_WIDTH-1:0]   s_awaddr,
    input  logic [2*13-1:0]           s_awctl,
    input  logic [1:0]                s_wvalid,
    output logic [1:0]                s_wready,
    input  logic [2*DATA_WIDTH-1:0]   s_wdata,
    input  logic [2*STRB_WIDTH-1:0]   s_wstrb,
    input  logic [1:0]                s_wlast,
    output logic [1:0]                s_bvalid,
    input  logic [1:0]                s_bready,
    output logic [2*ID_WIDTH-1:0]     s_bid,
    output logic [3:0]                s_bresp,
    output logic                      m_awvalid,
    input  logic                      m_awready,
    output logic [ID_WIDTH:0]         m_awid,
    output logic [ADDR_WIDTH-1:0]     m_awaddr,
    output logic [12:0]               m_awctl,
    output logic                      m_wvalid,
    input  logic                      m_wready,
    output logic [DATA_WIDTH-1:0]     m_wdata,
    output logic [STRB_WIDTH-1:0]     m_wstrb,
    output logic                      m_wlast,
    input  logic                      m_bvalid,
    output logic                      m_bready,
    input  logic [ID_WIDTH:0]         m_bid,
    input  logic [1:0]                m_bresp
);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_HOLD = 1'b1;
    localparam int unsigned PW = $clog2(WQ_DEPTH);
    localparam int unsigned CW = PW + 1;

    logic                  state_q, state_d;
    logic                  last_q, last_d;
    logic                  awvalid_q, awvalid_d;
    logic [ID_WIDTH:0]     awid_q, awid_d;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [12:0]           awctl_q, awctl_d;
    logic                  wq_q [WQ_DEPTH];
    logic [PW-1:0]         wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]         cnt_q, cnt_d;

    logic wq_full, wq_empty, grant, gnt_g, head, pop;

    always_comb begin
        wq_full  = (cnt_q == CW'(WQ_DEPTH));
        wq_empty = (cnt_q == '0);
        // Prefer the requester that did not win last time; fall back to the other.
        gnt_g = s_awvalid[~last_q] ? ~last_q : last_q;
        grant = (state_q == ST_IDLE) && (|s_awvalid) && !wq_full;

        s_awready = '0;
        if (grant && aresetn) s_awready[gnt_g] = 1'b1;

        head     = wq_q[rd_q];
        m_wvalid = !wq_empty && s_wvalid[head];
        m_wlast  = !wq_empty && s_wlast[head];
        m_wdata  = head ? s_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : s_wdata[DATA_WIDTH-1:0];
        m_wstrb  = head ? s_wstrb[2*STRB_WIDTH-1:STRB_WIDTH] : s_wstrb[STRB_WIDTH-1:0];
        s_wready = '0;
        if (!wq_empty) s_wready[head] = m_wready;
        pop = m_wvalid && m_wready && m_wlast;

        s_bvalid = '0;
        s_bvalid[m_bid[ID_WIDTH]] = m_bvalid;
        m_bready = s_bready[m_bid[ID_WIDTH]];
        s_bid    = {2{m_bid[ID_WIDTH-1:0]}};
        s_bresp  = {2{m_bresp}};
    end

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        awvalid_d = awvalid_q;
        awid_d    = awid_q;
        awaddr_d  = awaddr_q;
        awctl_d   = awctl_q;
        case (state_q)
            ST_IDLE: begin
                if (grant) begin
                    state_d   = ST_HOLD;
                    last_d    = gnt_g;
                    awvalid_d = 1'b1;
                    awid_d    = {gnt_g, gnt_g ? s_awid[2*ID_WIDTH-1:ID_WIDTH] : s_awid[ID_WIDTH-1:0]};
                    awaddr_d  = gnt_g ? s_awaddr[2*ADDR_WIDTH-1:ADDR_WIDTH] : s_awaddr[ADDR_WIDTH-1:0];
                    awctl_d   = gnt_g ? s_awctl[25:13] : s_awctl[12:0];
                end
            end
            ST_HOLD: begin
                if (m_awready) begin
                    state_d   = ST_IDLE;
                    awvalid_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        wr_d  = grant ? wr_q + PW'(1) : wr_q;
        rd_d  = pop ? rd_q + PW'(1) : rd_q;
        cnt_d = cnt_q;
        case ({grant, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= ST_IDLE;
            last_q    <= 1'b1;
            awvalid_q <= 1'b0;
            awid_q    <= '0;
            awaddr_q  <= '0;
            awctl_q   <= '0;
            wr_q      <= '0;
            rd_q      <= '0;
            cnt_q     <= '0;
            for (int unsigned i = 0; i < WQ_DEPTH; i++) wq_q[i] <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            awvalid_q <= awvalid_d;
            awid_q    <= awid_d;
            awaddr_q  <= awaddr_d;
            awctl_q   <= awctl_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            cnt_q     <= cnt_d;
            if (grant) wq_q[wr_q] <= gnt_g;
        end
    end

    assign m_awvalid = awvalid_q;
    assign m_awid    = awid_q;
    assign m_awaddr  = awaddr_q;
    assign m_awctl   = awctl_q;

endmodule

// File: tb/tb_axi_wr_arbiter_2to1.sv
// Bench for axi_wr_arbiter_2to1: B-routing vector table, directed corner
// sequences, then random traffic checked against a transaction-level model.
module tb_axi_wr_arbiter_2to1;
    localparam int AW = 32, DW = 32, IW = 4, SW = 4, NB = 12;

    logic aclk = 1'b0;
    logic aresetn;
    always #5 aclk = ~aclk;

    logic [1:0]      s_awvalid, s_awready, s_wvalid, s_wready, s_wlast, s_bvalid, s_bready;
    logic [2*IW-1:0] s_awid, s_bid;
    logic [2*AW-1:0] s_awaddr;
    logic [25:0]     s_awctl;
    logic [2*DW-1:0] s_wdata;
    logic [2*SW-1:0] s_wstrb;
    logic [3:0]      s_bresp;
    logic            m_awvalid, m_awready, m_wvalid, m_wready, m_wlast, m_bvalid, m_bready;
    logic [IW:0]     m_awid, m_bid;
    logic [AW-1:0]   m_awaddr;
    logic [12:0]     m_awctl;
    logic [DW-1:0]   m_wdata;
    logic [SW-1:0]   m_wstrb;
    logic [1:0]      m_bresp;

    logic          awv [2];
    logic [IW-1:0] awid [2];
    logic [AW-1:0] awaddr [2];
    logic [12:0]   awctl [2];
    logic          wv [2];
    logic [DW-1:0] wd [2];
    logic [SW-1:0] ws [2];
    logic          wl [2];
    logic          br [2];

    assign s_awvalid = {awv[1], awv[0]};
    assign s_awid    = {awid[1], awid[0]};
    assign s_awaddr  = {awaddr[1], awaddr[0]};
    assign s_awctl   = {awctl[1], awctl[0]};
    assign s_wvalid  = {wv[1], wv[0]};
    assign s_wdata   = {wd[1], wd[0]};
    assign s_wstrb   = {ws[1], ws[0]};
    assign s_wlast   = {wl[1], wl[0]};
    assign s_bready  = {br[1], br[0]};

    axi_wr_arbiter_2to1 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .WQ_DEPTH(4)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awid(s_awid), .s_awaddr(s_awaddr),
        .s_awctl(s_awctl), .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata),
        .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_bid(s_bid), .s_bresp(s_bresp),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awid(m_awid), .m_awaddr(m_awaddr),
        .m_awctl(m_awctl), .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata),
        .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_bid(m_bid), .m_bresp(m_bresp)
    );

    int nvec = 0;
    int nmis = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic timeout(input string nm);
        nvec++;
        nmis++;
        $display("FAIL %s: timed out waiting for handshake at %0t", nm, $time);
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic rst_on();
        aresetn   = 1'b0;
        m_awready = 1'b0;
        m_wready  = 1'b0;
        m_bvalid  = 1'b0;
        m_bid     = '0;
        m_bresp   = '0;
        for (int i = 0; i < 2; i++) begin
            awv[i] = 1'b0; awid[i] = '0; awaddr[i] = '0; awctl[i] = '0;
            wv[i] = 1'b0; wd[i] = '0; ws[i] = '0; wl[i] = 1'b0; br[i] = 1'b0;
        end
        repeat (2) step();
    endtask

    // ---------------- B-routing vector table ----------------
    typedef struct {
        logic       mbv;
        logic [4:0] mbid;
        logic [1:0] mbresp;
        logic [1:0] sbr;
        logic [1:0] e_sbv;
        logic       e_mbr;
        logic [7:0] e_sbid;
        logic [3:0] e_sbresp;
    } bvec_t;
    bvec_t bt [6];

    // ---------------- random-phase model state ----------------
    typedef struct packed { logic [3:0] id; logic [31:0] addr; logic [12:0] ctl; } aw_t;
    typedef struct packed { logic [31:0] d; logic [3:0] s; logic l; } wb_t;
    aw_t  aw_stim [2][NB];
    wb_t  w_stim  [2][$];
    aw_t  exp_aw  [2][$];
    wb_t  exp_w   [2][$];
    logic grant_q [$];
    logic worder  [$];
    logic [4:0] bq [$];

    task automatic aw_drv(input int i);
        for (int b = 0; b < NB; b++) begin
            logic hs;
            int   n;
            repeat ($urandom_range(0, 3)) step();
            awv[i] = 1'b1; awid[i] = aw_stim[i][b].id;
            awaddr[i] = aw_stim[i][b].addr; awctl[i] = aw_stim[i][b].ctl;
            hs = 1'b0; n = 0;
            while (!hs && n < 3000) begin
                @(negedge aclk);
                hs = s_awready[i];
                step();
                n++;
            end
            awv[i] = 1'b0;
            if (!hs) begin timeout("aw_drv"); return; end
        end
    endtask

    task automatic w_drv(input int i);
        for (int k = 0; k < w_stim[i].size(); k++) begin
            logic hs;
            int   n;
            repeat ($urandom_range(0, 2)) step();
            wv[i] = 1'b1; wd[i] = w_stim[i][k].d; ws[i] = w_stim[i][k].s; wl[i] = w_stim[i][k].l;
            hs = 1'b0; n = 0;
            while (!hs && n < 3000) begin
                @(negedge aclk);
                hs = s_wready[i] & s_wvalid[i];
                step();
                n++;
            end
            wv[i] = 1'b0;
            if (!hs) begin timeout("w_drv"); return; end
        end
    endtask

    task automatic master_proc(input int wtotal);
        logic       lastg = 1'b1;
        logic       w, r, bhs;
        logic [1:0] cur_resp = '0;
        int         wrem = wtotal;
        int         bdone = 0;
        int         cyc = 0;
        int         rb;
        aw_t        a;
        wb_t        e;
        while ((wrem > 0 || bdone < 2*NB) && cyc < 20000) begin
            @(negedge aclk);
            cyc++;
            if (m_wvalid && m_wready) begin
                if (worder.size() == 0 || exp_w[worder[0]].size() == 0) timeout("w_unexpected_beat");
                else begin
                    r = worder[0];
                    e = exp_w[r].pop_front();
                    chk("rw_route", s_wready, r ? 2'b10 : 2'b01);
                    chk("rw_beat", {m_wdata, m_wstrb, m_wlast}, e);
                    if (e.l) void'(worder.pop_front());
                    wrem--;
                end
            end
            if (s_awready != 2'b00) begin
                w = (s_awvalid == 2'b11) ? !lastg : s_awvalid[1];
                chk("rr_grant", s_awready, w ? 2'b10 : 2'b01);
                lastg = w;
                grant_q.push_back(w);
                worder.push_back(w);
            end
            bhs = 1'b0;
            if (m_bvalid && m_bready) begin
                rb = int'(bq[0][4]);
                chk("b_route", s_bvalid, bq[0][4] ? 2'b10 : 2'b01);
                chk("b_id", s_bid[rb*4 +: 4], bq[0][3:0]);
                chk("b_resp", s_bresp[rb*2 +: 2], cur_resp);
                void'(bq.pop_front());
                bdone++;
                bhs = 1'b1;
            end
            if (m_awvalid && m_awready) begin
                if (grant_q.size() == 0) timeout("aw_unexpected");
                else begin
                    r = grant_q.pop_front();
                    chk("aw_src", m_awid[4], r);
                    if (exp_aw[r].size() == 0) timeout("aw_extra");
                    else begin
                        a = exp_aw[r].pop_front();
                        chk("aw_payload", {m_awid[3:0], m_awaddr, m_awctl}, a);
                        bq.push_back({r, a.id});
                    end
                end
            end
            step();
            m_awready = ($urandom_range(0, 3) != 0);
            m_wready  = ($urandom_range(0, 3) != 0);
            br[0] = 1'($urandom_range(0, 1));
            br[1] = 1'($urandom_range(0, 1));
            if (bhs) m_bvalid = 1'b0;
            if (!m_bvalid && bq.size() > 0 && $urandom_range(0, 1) == 1) begin
                m_bvalid = 1'b1;
                m_bid    = bq[0];
                cur_resp = 2'($urandom);
                m_bresp  = cur_resp;
            end
        end
        if (wrem > 0 || bdone < 2*NB) timeout("random_drain");
        chk("aw_all_issued", exp_aw[0].size() + exp_aw[1].size(), 0);
    endtask

    initial begin
        int   ng, n, wtot;
        logic gb;

        bt[0] = '{1'b1, 5'h03, 2'd0, 2'b01, 2'b01, 1'b1, 8'h33, 4'b0000};
        bt[1] = '{1'b1, 5'h15, 2'd2, 2'b01, 2'b10, 1'b0, 8'h55, 4'b1010};
        bt[2] = '{1'b1, 5'h15, 2'd2, 2'b10, 2'b10, 1'b1, 8'h55, 4'b1010};
        bt[3] = '{1'b0, 5'h15, 2'd1, 2'b11, 2'b00, 1'b1, 8'h55, 4'b0101};
        bt[4] = '{1'b1, 5'h0A, 2'd3, 2'b10, 2'b01, 1'b0, 8'hAA, 4'b1111};
        bt[5] = '{1'b0, 5'h00, 2'd0, 2'b00, 2'b00, 1'b0, 8'h00, 4'b0000};

        // Reset state
        rst_on();
        chk("rst_awvalid", m_awvalid, 1'b0);
        chk("rst_awid", m_awid, 5'h00);
        chk("rst_awaddr", m_awaddr, 32'h0);
        chk("rst_wvalid", m_wvalid, 1'b0);
        chk("rst_wlast", m_wlast, 1'b0);
        chk("rst_wready", s_wready, 2'b00);

        // Single burst from s0
        aresetn = 1'b1;
        m_awready = 1'b1; m_wready = 1'b1;
        awv[0] = 1'b1; awid[0] = 4'h3; awaddr[0] = 32'h1000; awctl[0] = {8'd3, 3'd2, 2'd1};
        #1;
        chk("sb_awready", s_awready, 2'b01);
        chk("sb_awvalid_pre", m_awvalid, 1'b0);
        step();
        awv[0] = 1'b0;
        #1;
        chk("sb_awvalid", m_awvalid, 1'b1);
        chk("sb_awid", m_awid, 5'h03);
        chk("sb_awaddr", m_awaddr, 32'h1000);
        chk("sb_awctl", m_awctl, {8'd3, 3'd2, 2'd1});
        chk("sb_awready_hold", s_awready, 2'b00);
        for (int k = 0; k < 4; k++) begin
            wv[0] = 1'b1; wd[0] = 32'hA000_0000 + 32'(k); ws[0] = 4'hF; wl[0] = (k == 3);
            #1;
            if (k == 1) chk("sb_awvalid_drop", m_awvalid, 1'b0);
            chk("sb_wvalid", m_wvalid, 1'b1);
            chk("sb_wdata", m_wdata, 32'hA000_0000 + 32'(k));
            chk("sb_wlast", m_wlast, (k == 3));
            chk("sb_wready", s_wready, 2'b01);
            step();
        end
        wv[0] = 1'b1; wl[0] = 1'b0;
        #1;
        chk("sb_empty_wvalid", m_wvalid, 1'b0);
        chk("sb_empty_wready", s_wready, 2'b00);
        wv[0] = 1'b0;

        // B routing table
        for (int i = 0; i < 6; i++) begin
            m_bvalid = bt[i].mbv; m_bid = bt[i].mbid; m_bresp = bt[i].mbresp;
            br[0] = bt[i].sbr[0]; br[1] = bt[i].sbr[1];
            #1;
            chk("bt_bvalid", s_bvalid, bt[i].e_sbv);
            chk("bt_bready", m_bready, bt[i].e_mbr);
            chk("bt_bid", s_bid, bt[i].e_sbid);
            chk("bt_bresp", s_bresp, bt[i].e_sbresp);
        end

        // Contention: both requesters valid from reset
        rst_on();
        m_awready = 1'b1;
        awv[0] = 1'b1; awid[0] = 4'h1; awv[1] = 1'b1; awid[1] = 4'h2;
        aresetn = 1'b1;
        #1;
        for (int g = 0; g < 4; g++) begin
            gb = (g % 2) == 1;
            n = 0;
            while (s_awready == 2'b00 && n < 8) begin step(); n++; end
            chk("ct_grant", s_awready, gb ? 2'b10 : 2'b01);
            step();
            chk("ct_awid", m_awid, {gb, gb ? 4'h2 : 4'h1});
        end

        // AW backpressure
        rst_on();
        aresetn = 1'b1;
        awv[0] = 1'b1; awid[0] = 4'h7; awaddr[0] = 32'h2000; awctl[0] = 13'h0055;
        #1;
        chk("bp_awready", s_awready, 2'b01);
        step();
        awv[0] = 1'b0; awv[1] = 1'b1; awid[1] = 4'h9;
        #1;
        repeat (5) begin
            chk("bp_awvalid", m_awvalid, 1'b1);
            chk("bp_awaddr", m_awaddr, 32'h2000);
            chk("bp_awid", m_awid, 5'h07);
            chk("bp_awready", s_awready, 2'b00);
            step();
        end
        wv[0] = 1'b1; wv[1] = 1'b1; m_wready = 1'b1;
        #1;
        chk("bp_qhead", s_wready, 2'b01);
        wv[0] = 1'b0; wv[1] = 1'b0; m_wready = 1'b0;
        m_awready = 1'b1;
        #1;
        chk("bp_awvalid_last", m_awvalid, 1'b1);
        step();
        chk("bp_awvalid_drop", m_awvalid, 1'b0);
        chk("bp_next_grant", s_awready, 2'b10);
        awv[1] = 1'b0;

        // Queue full
        rst_on();
        aresetn = 1'b1;
        m_awready = 1'b1;
        awv[0] = 1'b1;
        #1;
        ng = 0;
        repeat (10) begin
            if (s_awready != 2'b00) ng++;
            step();
        end
        chk("qf_grants", ng, 4);
        repeat (4) begin
            chk("qf_blocked", s_awready, 2'b00);
            step();
        end
        wv[0] = 1'b1; wl[0] = 1'b1; m_wready = 1'b1;
        #1;
        chk("qf_pop_cycle", s_awready, 2'b00);
        chk("qf_pop_wlast", m_wlast, 1'b1);
        step();
        wv[0] = 1'b0; wl[0] = 1'b0; m_wready = 1'b0;
        #1;
        chk("qf_regrant", s_awready, 2'b01);

        // Reset in the middle of an s1 burst
        rst_on();
        aresetn = 1'b1;
        m_awready = 1'b1; m_wready = 1'b1;
        awv[1] = 1'b1; awid[1] = 4'h5;
        #1;
        chk("rm_grant", s_awready, 2'b10);
        step();
        awv[1] = 1'b0; wv[1] = 1'b1; wd[1] = 32'h11; wl[1] = 1'b0;
        step();
        wd[1] = 32'h22;
        #1;
        chk("rm_beat2", s_wready, 2'b10);
        awv[0] = 1'b1; awv[1] = 1'b1;
        aresetn = 1'b0;
        #1;
        chk("rm_awvalid", m_awvalid, 1'b0);
        chk("rm_wready", s_wready, 2'b00);
        chk("rm_wvalid", m_wvalid, 1'b0);
        chk("rm_awready", s_awready, 2'b00);
        wv[1] = 1'b0;
        step();
        aresetn = 1'b1;
        #1;
        chk("rm_first_grant", s_awready, 2'b01);

        // Random traffic against the transaction model
        rst_on();
        wtot = 0;
        for (int i = 0; i < 2; i++) begin
            for (int b = 0; b < NB; b++) begin
                int   len;
                aw_t  a;
                wb_t  e;
                len = $urandom_range(0, 3);
                a.id = 4'($urandom); a.addr = $urandom; a.ctl = {8'(len), 3'd2, 2'd1};
                aw_stim[i][b] = a;
                exp_aw[i].push_back(a);
                for (int k = 0; k <= len; k++) begin
                    e.d = $urandom; e.s = 4'($urandom); e.l = (k == len);
                    w_stim[i].push_back(e);
                    exp_w[i].push_back(e);
                    wtot++;
                end
            end
        end
        aresetn = 1'b1;
        fork
            aw_drv(0);
            aw_drv(1);
            w_drv(0);
            w_drv(1);
            master_proc(wtot);
        join

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
